// File: rtl/rt_pkg.sv
// Shared definitions for the reaction-time tester.
//   - default timing constants (25 MHz clock, 1 ms tick)
//   - state encoding; the codes are visible on uo_out[6:4]
//   - LFSR seed and next-state function
package rt_pkg;

    localparam int TICKS_PER_MS_DEF = 25000;
    localparam int MIN_DELAY_MS_DEF = 1000;
    localparam int DELAY_MASK_DEF   = 2047;
    localparam int MAX_MS_DEF       = 4095;
    localparam int RES_W            = 12;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ARMED   = 3'd2,
        ST_DONE    = 3'd3,
        ST_EARLY   = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_t;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting left.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioning: 2-FF synchronizer followed by a rising-edge detector.
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   pin  : raw asynchronous button input
//   rise : one-cycle pulse; high during the cycle before the 3rd clock edge
//          after the pin rises, so the consumer acts on that 3rd edge
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    always_comb begin
        s1_d   = pin;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/tt_um_DelosReyesJordan_HDL.sv
// TinyTapeout user-slot wrapper: maps the slot pins straight onto the core.
//   Reset is passed through unchanged; the core treats rst_n as active-high.
module tt_um_DelosReyesJordan_HDL (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    reaction_time_tester u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

endmodule

// File: rtl/reaction_time_tester.sv
// Reaction-time tester core.
//   clk     : system clock
//   rst_n   : asynchronous reset, ACTIVE-HIGH (name inherited from the wrapper)
//   ena     : ignored
//   ui_in   : [0] start, [1] react, [2] result byte select, [7:3] unused
//   uio_in  : unused
//   uo_out  : [0] LED, [1] early, [2] done, [3] timeout, [6:4] state, [7] ms heartbeat
//   uio_out : result[7:0] when ui_in[2]=0, {4'b0, result[11:8]} when ui_in[2]=1
//   uio_oe  : all outputs enabled
module reaction_time_tester
    import rt_pkg::*;
#(
    parameter int TICKS_PER_MS = TICKS_PER_MS_DEF,
    parameter int MIN_DELAY_MS = MIN_DELAY_MS_DEF,
    parameter int DELAY_MASK   = DELAY_MASK_DEF,
    parameter int MAX_MS       = MAX_MS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int DW = $clog2(MIN_DELAY_MS + DELAY_MASK + 1);

    logic rst;
    assign rst = rst_n;

    logic start_rise, react_rise;

    btn_sync_edge u_start (.clk(clk), .rst(rst), .pin(ui_in[0]), .rise(start_rise));
    btn_sync_edge u_react (.clk(clk), .rst(rst), .pin(ui_in[1]), .rise(react_rise));

    state_t           state_q, state_d;
    logic [RES_W-1:0] result_q, result_d;
    logic [DW-1:0]    delay_q, delay_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             led_q, led_d;
    logic             early_q, early_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             hb_q, hb_d;

    logic             tick;
    logic [DW-1:0]    delay_load;
    logic [RES_W-1:0] result_inc;

    assign tick       = (presc_q == PW'(TICKS_PER_MS - 1));
    assign delay_load = DW'(MIN_DELAY_MS) + DW'(lfsr_q[10:0] & 11'(DELAY_MASK));
    assign result_inc = result_q + 12'd1;

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        delay_d   = delay_q;
        led_d     = led_q;
        early_d   = early_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        lfsr_d    = lfsr_next(lfsr_q);
        hb_d      = hb_q ^ tick;

        case (state_q)
            ST_IDLE, ST_DONE, ST_EARLY, ST_TIMEOUT: begin
                // React edges are ignored here; start always begins a new trial.
                if (start_rise) begin
                    state_d   = ST_WAIT;
                    delay_d   = delay_load;
                    result_d  = '0;
                    led_d     = 1'b0;
                    early_d   = 1'b0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_WAIT: begin
                // React beats a same-cycle delay expiry.
                if (react_rise) begin
                    state_d = ST_EARLY;
                    early_d = 1'b1;
                end else if (tick) begin
                    if (delay_q <= DW'(1)) begin
                        state_d = ST_ARMED;
                        delay_d = '0;
                        led_d   = 1'b1;
                    end else begin
                        delay_d = delay_q - DW'(1);
                    end
                end
            end
            ST_ARMED: begin
                // React beats a same-cycle tick; that tick is dropped.
                if (react_rise) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    led_d   = 1'b0;
                end else if (tick) begin
                    result_d = result_inc;
                    if (result_inc == RES_W'(MAX_MS)) begin
                        state_d   = ST_TIMEOUT;
                        timeout_d = 1'b1;
                        led_d     = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every state entry restarts the ms phase so a full ms elapses before the first tick.
        presc_d = (state_d != state_q || tick) ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            delay_q   <= '0;
            presc_q   <= '0;
            lfsr_q    <= LFSR_SEED;
            led_q     <= 1'b0;
            early_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            hb_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            delay_q   <= delay_d;
            presc_q   <= presc_d;
            lfsr_q    <= lfsr_d;
            led_q     <= led_d;
            early_q   <= early_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            hb_q      <= hb_d;
        end
    end

    assign uo_out  = {hb_q, state_q, timeout_q, done_q, early_q, led_q};
    assign uio_out = ui_in[2] ? {4'b0000, result_q[11:8]} : result_q[7:0];
    assign uio_oe  = 8'hFF;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_reaction_time_tester.sv
// Self-checking bench for reaction_time_tester with small timing parameters.
module tb_reaction_time_tester;

    localparam int TPM  = 4;
    localparam int MIND = 2;
    localparam int MASK = 3;
    localparam int MAXM = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       start_pin, react_pin, sel;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

    assign ui_in = {5'b00000, sel, react_pin, start_pin};

    reaction_time_tester #(
        .TICKS_PER_MS(TPM), .MIN_DELAY_MS(MIND), .DELAY_MASK(MASK), .MAX_MS(MAXM)
    ) dut (
        .clk    (clk),
        .rst_n  (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; the LFSR has advanced exactly this many steps.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_after(input int n);
        logic [15:0] v = 16'hACE1;
        for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int st();
        return int'(uo_out[6:4]);
    endfunction

    // Start press from a negedge; returns at the negedge after the acting edge
    // with the delay the DUT must have loaded.
    task automatic press_start(output int d);
        int c;
        c = cyc;
        start_pin = 1'b1;
        step(1);
        start_pin = 1'b0;
        step(2);
        d = MIND + int'(lfsr_after(c + 2) & 16'(MASK));
        chk("start_state", st(), 1);
        chk("start_flags", int'(uo_out[3:0]), 0);
        chk("start_result", int'(uio_out), 0);
    endtask

    task automatic press_react();
        react_pin = 1'b1;
        step(1);
        react_pin = 1'b0;
        step(2);
    endtask

    // kind 0: react in ARMED after r cycles, 1: early press, 2: timeout
    task automatic run_trial(input int kind, input int r);
        int d, e, res;
        press_start(d);
        if (kind == 1) begin
            e = $urandom_range(1, 4 * d - 3);
            step(e);
            press_react();
            chk("early_state", st(), 4);
            chk("early_flags", int'(uo_out[3:0]), 4'b0010);
            chk("early_result", int'(uio_out), 0);
            step(4 * d - e + 2);
            chk("early_noled_state", st(), 4);
            chk("early_noled", int'(uo_out[0]), 0);
            return;
        end
        if (kind == 2) begin
            // start during WAIT must not restart the delay
            start_pin = 1'b1;
            step(1);
            start_pin = 1'b0;
            step(4 * d - 2);
        end else begin
            step(4 * d - 1);
        end
        chk("wait_before_led", int'(uo_out[6:0]), {3'd1, 4'b0000});
        step(1);
        chk("led_on", int'(uo_out[6:0]), {3'd2, 4'b0001});
        if (kind == 0) begin
            res = (r + 2) / 4;
            step(r);
            react_pin = 1'b1;
            step(1);
            react_pin = 1'b0;
            step(1);
            chk("armed_before_react", st(), 2);
            step(1);
            chk("done_out", int'(uo_out[6:0]), {3'd3, 4'b0100});
            chk("done_result_lo", int'(uio_out), res);
            sel = 1'b1; #1;
            chk("done_result_hi", int'(uio_out), 0);
            sel = 1'b0;
            press_react();
            chk("done_react_ignored", int'(uo_out[6:0]), {3'd3, 4'b0100});
            chk("done_hold_result", int'(uio_out), res);
        end else begin
            step(4 * MAXM - 1);
            chk("pre_timeout_state", st(), 2);
            chk("pre_timeout_result", int'(uio_out), MAXM - 1);
            step(1);
            chk("timeout_out", int'(uo_out[6:0]), {3'd5, 4'b1000});
            chk("timeout_result", int'(uio_out), MAXM);
            sel = 1'b1; #1;
            chk("timeout_result_hi", int'(uio_out), 0);
            sel = 1'b0;
            step(6);
            chk("timeout_hold", int'(uio_out), MAXM);
        end
    endtask

    initial begin
        int d;
        rst = 1'b1; ena = 1'b1; uio_in = 8'h00;
        start_pin = 1'b0; react_pin = 1'b0; sel = 1'b0;
        step(3);
        chk("rst_uo", int'(uo_out), 0);
        chk("rst_uio", int'(uio_out), 0);
        chk("rst_oe", int'(uio_oe), 8'hFF);
        rst = 1'b0;
        step(2);
        chk("idle_uo", int'(uo_out), 0);
        chk("idle_state", st(), 0);
        press_react();
        chk("idle_react_ignored", st(), 0);

        run_trial(0, 28);
        step($urandom_range(1, 9));
        run_trial(1, 0);
        step($urandom_range(1, 9));
        run_trial(2, 0);
        for (int t = 0; t < 10; t++) begin
            step($urandom_range(1, 13));
            run_trial(int'($urandom_range(0, 2)), int'($urandom_range(1, 76)));
        end

        // Asynchronous reset in the middle of ARMED
        step(3);
        press_start(d);
        step(4 * d + 10);
        chk("mid_armed", st(), 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_uo", int'(uo_out), 0);
        chk("async_rst_uio", int'(uio_out), 0);
        chk("async_rst_oe", int'(uio_oe), 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        chk("post_rst_state", st(), 0);
        run_trial(0, int'($urandom_range(1, 76)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reaction_time_tester.md
Name: reaction_time_tester

Overview:
- Single-player reaction-time tester in the TinyTapeout user slot (top-level wrapper tt_um_DelosReyesJordan_HDL, 25 MHz clock).
- Start button begins a trial; a pseudo-random delay elapses, then the stimulus LED lights.
- Elapsed milliseconds until the react button is pressed are measured and shown on uio_out; status flags appear on uo_out.

Parameters:
- TICKS_PER_MS, 25000, clock cycles per 1 ms tick (25 MHz).
- MIN_DELAY_MS, 1000, minimum random delay before stimulus.
- DELAY_MASK, 2047, random part of delay = lfsr[10:0] & DELAY_MASK; total delay range MIN_DELAY_MS..MIN_DELAY_MS+DELAY_MASK ms.
- MAX_MS, 4095, reaction-count saturation and timeout value (12-bit result).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-high (asserted when 1; name kept from the TinyTapeout wrapper).
- ena  in  1  design-selected indicator; ignored, outputs always valid.
- ui_in  in  8  [0] start button, [1] react button, [2] result byte select (0 = low byte, 1 = high nibble), [7:3] unused.
- uio_in  in  8  unused.
- uo_out  out  8  [0] stimulus LED, [1] early flag, [2] done flag, [3] timeout flag, [6:4] state code, [7] ms-tick heartbeat (toggles each ms tick).
- uio_out  out  8  ui_in[2]=0: result[7:0]; ui_in[2]=1: {4'b0, result[11:8]}.
- uio_oe  out  8  constant 8'hFF.

Behaviour:
- Reset (async, active-high):
  - state = IDLE; result = 0; all flags 0; LFSR = 16'hACE1.
  - Prescaler and delay counter = 0; synchronizer flops = 0.
  - uo_out = 0; uio_out = 0; uio_oe = FF.
- Inputs ui_in[0] and ui_in[1]:
  - Each passes a 2-FF synchronizer, then a rising-edge detect.
  - A pin rise is acted on in the 3rd clock edge after it.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Free-runs every cycle except during reset.
- ms tick: prescaler counts 0..TICKS_PER_MS-1; tick is asserted on the wrap cycle. The prescaler is cleared on every state entry.
- State codes: IDLE=0, WAIT=1, ARMED=2, DONE=3, EARLY=4, TIMEOUT=5.
- IDLE:
  - start edge -> WAIT.
  - delay_ms = MIN_DELAY_MS + (lfsr & DELAY_MASK); result = 0; flags cleared.
- WAIT:
  - react edge -> EARLY (early=1). React has priority over delay expiry in the same cycle.
  - Each tick decrements delay_ms; the tick that takes delay_ms to 0 -> ARMED.
  - start edge is ignored.
- ARMED:
  - LED=1; result increments on each tick.
  - react edge -> DONE: result frozen, done=1, LED=0. React has priority over a tick in the same cycle; that tick is not counted.
  - result reaching MAX_MS -> TIMEOUT: timeout=1, result holds MAX_MS, LED=0.
- DONE / EARLY / TIMEOUT:
  - Outputs hold.
  - start edge -> WAIT with a new delay; result and flags cleared.
  - react edges are ignored.
- Simultaneous start and react edges: start wins in IDLE/DONE/EARLY/TIMEOUT; react wins in WAIT/ARMED.
- Reset asserted mid-trial returns immediately to reset values.
- Result width is 12 bits and never wraps.

Decomposition:
- Shared package rt_pkg: state enum (codes above), default parameter constants, LFSR seed 16'hACE1.
- One natural sub-module: btn_sync_edge (2-FF synchronizer plus rising-edge pulse), instantiated twice.
- Top-level wrapper tt_um_DelosReyesJordan_HDL only maps TinyTapeout pins to reaction_time_tester.

Test Plan (TICKS_PER_MS=4, MIN_DELAY_MS=2, DELAY_MASK=3, MAX_MS=20):
- Reset held, then released -> uo_out=00, uio_out=00, uio_oe=FF, state code 0.
- Start pulse -> state 1. First lfsr & 3 after reset is computable from seed ACE1; LED rises exactly (2 + that value)*4 cycles after WAIT entry (±1 for the tick-edge convention).
- Reaction run: react rise 7 ticks (28 cycles) after LED -> state 3, done=1, LED=0, uio_out=07 with ui_in[2]=0, 00 with ui_in[2]=1.
- Early press: react rise during WAIT -> state 4, early=1, LED never lights, result 0. Then start -> state 1, flags cleared.
- Timeout: no react for 20 ticks after LED -> state 5, timeout=1, uio_out=0x14. Start begins a new trial.
- Async reset asserted mid-ARMED -> outputs return to reset values without a clock edge; reset released -> IDLE.
